// File: rtl/mem_arbiter_pkg.sv
// Shared owner encoding and requester indices for the mem_arbiter slice.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_IF    = 2'd1,
        OWN_LS_RD = 2'd2,
        OWN_LS_WR = 2'd3
    } owner_t;

    localparam int REQ_IF  = 0;
    localparam int REQ_LS  = 1;
    localparam int NUM_REQ = 2;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Winner select between IF and LS: fixed LS priority with an IF starvation guard,
// or round-robin when ARB_RR_EN is defined. Grants are forced low while in reset.
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_gnt
);

    logic w_pickLs;

`ifdef ARB_RR_EN
    logic r_lastLs;

    always_comb begin
        w_pickLs = i_req[REQ_LS];
        o_gnt    = '0;
        if (i_req[REQ_LS] && i_req[REQ_IF]) begin
            w_pickLs = !r_lastLs;
        end
        if (rstn) begin
            o_gnt[REQ_LS] = i_req[REQ_LS] && w_pickLs;
            o_gnt[REQ_IF] = i_req[REQ_IF] && !w_pickLs;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_lastLs <= 1'b0;
        end else if (|o_gnt) begin
            r_lastLs <= o_gnt[REQ_LS];
        end
    end
`else
    localparam int CW = 4;

    logic [CW-1:0] r_starve;
    logic          w_starved;

    assign w_starved = (r_starve == CW'(STARVE_MAX));

    always_comb begin
        w_pickLs = i_req[REQ_LS] && !(i_req[REQ_IF] && w_starved);
        o_gnt    = '0;
        if (rstn) begin
            o_gnt[REQ_LS] = w_pickLs;
            o_gnt[REQ_IF] = i_req[REQ_IF] && !w_pickLs;
        end
    end

    // Counts consecutive cycles IF has waited; holds at STARVE_MAX until IF wins.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_starve <= '0;
        end else if (i_req[REQ_IF] && !o_gnt[REQ_IF]) begin
            if (!w_starved) begin
                r_starve <= r_starve + CW'(1);
            end
        end else begin
            r_starve <= '0;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port BRAM between instruction fetch and load/store, routing
// read data back to the issuer. Define ARB_RR_EN for round-robin arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    input  logic [DW/8-1:0] ls_be,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [DW-1:0]   ls_rdata,
    output logic            mem_en,
    output logic [DW/8-1:0] mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_gnt;
    owner_t             r_owner;
    owner_t             w_ownerNext;

    always_comb begin
        w_req         = '0;
        w_req[REQ_IF] = if_req;
        w_req[REQ_LS] = ls_req;
    end

    arb_pick #(
        .STARVE_MAX(STARVE_MAX)
    ) u_arbPick (
        .clk   (clk),
        .rstn  (rstn),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign if_gnt    = w_gnt[REQ_IF];
    assign ls_gnt    = w_gnt[REQ_LS];
    assign mem_en    = |w_gnt;
    assign mem_wdata = ls_wdata;

    always_comb begin
        w_ownerNext = OWN_NONE;
        mem_we      = '0;
        mem_addr    = if_addr;
        if (w_gnt[REQ_LS]) begin
            mem_addr = ls_addr;
            if (ls_we) begin
                mem_we      = ls_be;
                w_ownerNext = OWN_LS_WR;
            end else begin
                w_ownerNext = OWN_LS_RD;
            end
        end else if (w_gnt[REQ_IF]) begin
            w_ownerNext = OWN_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_ownerNext;
        end
    end

    // Responses are suppressed while reset is asserted so an in-flight read is dropped.
    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rvalid = 1'b0;
        ls_rdata  = '0;
        if (rstn) begin
            unique case (r_owner)
                OWN_IF: begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
                OWN_LS_RD: begin
                    ls_rvalid = 1'b1;
                    ls_rdata  = mem_rdata;
                end
                OWN_LS_WR: begin
                    ls_rvalid = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a cycle-level arbitration/memory model predicts
// grants and responses; a separate monitor compares every presented response.
module tb_mem_arbiter;

    localparam int AW         = 10;
    localparam int DW         = 32;
    localparam int BW         = DW / 8;
    localparam int STARVE_MAX = 4;
    localparam int WORDS      = 1 << AW;

    typedef struct {
        int            cyc;
        bit            isLs;
        logic [DW-1:0] data;
    } resp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic [BW-1:0] ls_be;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_en;
    logic [BW-1:0] mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    resp_t         sbq[$];
    logic [DW-1:0] shadow [0:WORDS-1];
    logic [DW-1:0] bram   [0:WORDS-1] = '{4: 32'hDEADBEEF, default: 32'h0};

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_be(ls_be), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port BRAM with byte writes and one-cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < BW; b++) begin
                if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= bram[mem_addr];
        end
    end

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: decides the winner from the arbitration rules, tracks the
    // expected memory contents and queues the response due the following cycle.
    initial begin
        int ifWait;
        bit lastLs;
        bit expIf;
        bit expLs;
        resp_t e;
        ifWait = 0;
        lastLs = 1'b0;
        for (int a = 0; a < WORDS; a++) shadow[a] = '0;
        shadow[4] = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            expIf = 1'b0;
            expLs = 1'b0;
            if (rstn !== 1'b1) begin
                ifWait = 0;
                lastLs = 1'b0;
            end else begin
`ifdef ARB_RR_EN
                if (if_req && ls_req) begin
                    expLs = !lastLs;
                    expIf = lastLs;
                end else begin
                    expLs = ls_req;
                    expIf = if_req;
                end
`else
                if (if_req && (ifWait >= STARVE_MAX || !ls_req)) expIf = 1'b1;
                else expLs = ls_req;
`endif
            end
            checkOutput("if_gnt", if_gnt, expIf);
            checkOutput("ls_gnt", ls_gnt, expLs);
            checkOutput("mem_en", mem_en, expIf | expLs);
            checkOutput("mem_we", mem_we, (expLs && ls_we) ? ls_be : '0);
            if (expIf || expLs) checkOutput("mem_addr", mem_addr, expLs ? ls_addr : if_addr);
            if (expLs && ls_we) checkOutput("mem_wdata", mem_wdata, ls_wdata);
            if (rstn === 1'b1) begin
                if (expIf || expLs) lastLs = expLs;
                if (if_req && !expIf) ifWait++;
                else ifWait = 0;
                e.cyc = cyc;
                if (expIf) begin
                    e.isLs = 1'b0;
                    e.data = shadow[if_addr];
                    sbq.push_back(e);
                end else if (expLs) begin
                    e.isLs = 1'b1;
                    if (ls_we) begin
                        e.data = '0;
                        for (int b = 0; b < BW; b++)
                            if (ls_be[b]) shadow[ls_addr][8*b +: 8] = ls_wdata[8*b +: 8];
                    end else begin
                        e.data = shadow[ls_addr];
                    end
                    sbq.push_back(e);
                end
            end
        end
    end

    // Monitor: a response is due exactly one cycle after its grant, unless reset intervenes.
    initial begin
        bit    due;
        resp_t e;
        forever begin
            @(negedge clk);
            due = (sbq.size() > 0) && (sbq[0].cyc == cyc - 1);
            if (due) e = sbq.pop_front();
            if (rstn !== 1'b1 || !due) begin
                checkOutput("if_rvalid idle", if_rvalid, 1'b0);
                checkOutput("ls_rvalid idle", ls_rvalid, 1'b0);
                checkOutput("if_rdata idle", if_rdata, '0);
                checkOutput("ls_rdata idle", ls_rdata, '0);
            end else if (e.isLs) begin
                checkOutput("ls_rvalid", ls_rvalid, 1'b1);
                checkOutput("if_rvalid quiet", if_rvalid, 1'b0);
                checkOutput("ls_rdata", ls_rdata, e.data);
                checkOutput("if_rdata quiet", if_rdata, '0);
            end else begin
                checkOutput("if_rvalid", if_rvalid, 1'b1);
                checkOutput("ls_rvalid quiet", ls_rvalid, 1'b0);
                checkOutput("if_rdata", if_rdata, e.data);
                checkOutput("ls_rdata quiet", ls_rdata, '0);
            end
        end
    end

    task automatic applyStimulus(input logic rst, input logic ir, input logic [AW-1:0] ia,
                                 input logic lr, input logic lw, input logic [AW-1:0] la,
                                 input logic [DW-1:0] lwd, input logic [BW-1:0] lbe);
        @(posedge clk);
        #1;
        rstn     = rst;
        if_req   = ir;
        if_addr  = ia;
        ls_req   = lr;
        ls_we    = lw;
        ls_addr  = la;
        ls_wdata = lwd;
        ls_be    = lbe;
    endtask

    initial begin
        logic [9:0] pat;
        logic [9:0] expPat;
        bit         ifPend;
        bit         lsPend;
        logic          nIr, nLr, nLw;
        logic [AW-1:0] nIa, nLa;
        logic [DW-1:0] nWd;
        logic [BW-1:0] nBe;

        rstn = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
        ls_addr = '0; ls_wdata = '0; ls_be = '0;

        $display("[TB] reset held with both requests asserted");
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 10'h004, 1'b1, 1'b0, 10'h020, '0, '0);
        applyStimulus(1'b1, 1'b1, 10'h004, 1'b1, 1'b0, 10'h020, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

        $display("[TB] IF read, LS write then read-back");
        applyStimulus(1'b1, 1'b1, 10'h004, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b1, 10'h010, 32'h12345678, 4'b0011);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 10'h010, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

        $display("[TB] continuous contention");
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 10'h004, 1'b1, 1'b0, 10'h010, '0, '0);
            #2;
            pat = {pat[8:0], ls_gnt};
        end
`ifdef ARB_RR_EN
        expPat = 10'b1010101010;
`else
        expPat = 10'b1111011110;
`endif
        checkOutput("contention grant pattern", DW'(pat), DW'(expPat));

        $display("[TB] back-to-back grants and reset after a grant");
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b1, 10'h004, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0, 10'h010, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b1, 10'h004, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

        $display("[TB] randomized traffic");
        ifPend = 1'b0; lsPend = 1'b0;
        nIr = 1'b0; nLr = 1'b0; nLw = 1'b0; nIa = '0; nLa = '0; nWd = '0; nBe = '0;
        for (int i = 0; i < 2000; i++) begin
            if (!ifPend) begin
                nIr = ($urandom_range(0, 99) < 60);
                nIa = AW'($urandom_range(0, 31));
            end
            if (!lsPend) begin
                nLr = ($urandom_range(0, 99) < 60);
                nLw = $urandom_range(0, 1) == 1;
                nLa = AW'($urandom_range(0, 31));
                nWd = $urandom;
                nBe = BW'($urandom_range(0, 15));
            end
            applyStimulus(($urandom_range(0, 99) != 0), nIr, nIa, nLr, nLw, nLa, nWd, nBe);
            #2;
            ifPend = if_req && !if_gnt;
            lsPend = ls_req && !ls_gnt;
        end

        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
